alu_share_sched: RTL and testbench



---
 rtl/alu_share_if.sv | 28 ++
 rtl/alu_share_sched.sv | 131 +++++++++++++
 tb/tb_alu_share_sched.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_if.sv
// Request/response bundle between two control-path clients and the shared ALU scheduler.
interface alu_share_if;
  logic       req0_valid, req0_ready;
  logic [1:0] req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [1:0] req1_op;
  logic [7:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id, rsp_flag;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_flag,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_flag,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_sched.sv
// Round-robin scheduler sharing one 8-bit ADD/SUB/PACK/ASHR unit between two requesters.
module alu_share_sched (
  input  logic         clk,
  input  logic         rst,
  alu_share_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_PACK = 2'b10, OP_ASHR = 2'b11;

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic [1:0] op_q, op_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic       id_q, id_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_flag_q, rsp_flag_d, rsp_id_q, rsp_id_d;

  logic [1:0]       vld;
  logic [1:0][1:0]  rq_op;
  logic [1:0][7:0]  rq_a, rq_b;
  logic [1:0]       grant;
  logic             gid;
  logic [8:0]       sum;
  logic [7:0]       diff, shr;

  assign vld   = {bus.req1_valid, bus.req0_valid};
  assign rq_op = {bus.req1_op, bus.req0_op};
  assign rq_a  = {bus.req1_a, bus.req0_a};
  assign rq_b  = {bus.req1_b, bus.req0_b};

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = a_q - b_q;
  assign shr  = {a_q[7], a_q[7:1]};

  // prio names the favoured port when both are valid
  always_comb begin
    grant = 2'b00;
    if (!rst && state_q == IDLE) begin
      grant[0] = vld[0] & (~vld[1] | ~prio_q);
      grant[1] = vld[1] & (~vld[0] |  prio_q);
    end
  end
  assign gid = grant[1];

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_flag   = rsp_flag_q;
  assign bus.rsp_id     = rsp_id_q;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_flag_d = rsp_flag_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          op_d    = rq_op[gid];
          a_d     = rq_a[gid];
          b_d     = rq_b[gid];
          id_d    = gid;
          cnt_d   = rq_b[gid][3:0];
          prio_d  = ~gid;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_id_d   = id_q;
        rsp_flag_d = 1'b0;
        state_d    = DONE;
        case (op_q)
          OP_ADD:  {rsp_flag_d, rsp_data_d} = sum;
          OP_SUB: begin
            rsp_data_d = diff;
            rsp_flag_d = (a_q[7] ^ b_q[7]) & (diff[7] ^ a_q[7]);
          end
          OP_PACK: rsp_data_d = {a_q[7:6], b_q[5:4], a_q[3:2], b_q[1:0]};
          default: begin
            // a_q doubles as the shift working register; n=0 still takes one cycle
            if (cnt_q <= 4'd1) begin
              rsp_data_d = (cnt_q == 4'd0) ? a_q : shr;
            end else begin
              a_d     = shr;
              cnt_d   = cnt_q - 4'd1;
              state_d = EXEC;
            end
          end
        endcase
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      op_q       <= 2'b00;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      id_q       <= 1'b0;
      cnt_q      <= 4'd0;
      rsp_data_q <= 8'h00;
      rsp_flag_q <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_flag_q <= rsp_flag_d;
      rsp_id_q   <= rsp_id_d;
    end
  end
endmodule

// File: tb/tb_alu_share_sched.sv
// Directed bench for alu_share_sched: op results, latency, arbitration, backpressure, reset.
module tb_alu_share_sched;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  alu_share_if bus();
  alu_share_sched dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // all input changes land 1 time unit after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input bit v, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  function automatic logic ready_of(input bit id);
    return id ? bus.req1_ready : bus.req0_ready;
  endfunction

  // grant in cycle T, then count cycles until rsp_valid, then complete the handshake
  task automatic do_op(input string tag, input bit id, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic ef, input int lat);
    int k;
    tick();
    set_req(id, 1'b1, op, a, b);
    #1;
    chk({tag, "_grant"}, {31'd0, ready_of(id)}, 32'd1);
    tick();
    set_req(id, 1'b0, op, a, b);
    k = 1;
    while (!bus.rsp_valid && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_data"}, {24'd0, bus.rsp_data}, {24'd0, ed});
    chk({tag, "_flag"}, {31'd0, bus.rsp_flag}, {31'd0, ef});
    chk({tag, "_id"}, {31'd0, bus.rsp_id}, {31'd0, id});
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, "_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] ca [2];
    logic [7:0] cb [2];
    int         left [2];
    int         k, gid, seen;
    logic [7:0] exp_d;

    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 2'b00, 8'h11, 8'h22);
    set_req(1'b1, 1'b1, 2'b00, 8'h33, 8'h44);
    tick(); tick();
    chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
    chk("rst_valid",  {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_data",   {24'd0, bus.rsp_data}, 32'd0);
    chk("rst_id",     {31'd0, bus.rsp_id}, 32'd0);
    chk("rst_flag",   {31'd0, bus.rsp_flag}, 32'd0);
    set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    rst = 1'b0;

    do_op("add",     1'b0, 2'b00, 8'hF0, 8'h20, 8'h10, 1'b1, 2);
    do_op("sub_ovf", 1'b1, 2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 2);
    do_op("sub",     1'b0, 2'b01, 8'h05, 8'h07, 8'hFE, 1'b0, 2);
    do_op("pack",    1'b1, 2'b10, 8'hC3, 8'h3C, 8'hF0, 1'b0, 2);
    do_op("ashr3",   1'b0, 2'b11, 8'h90, 8'h03, 8'hF2, 1'b0, 4);
    do_op("ashr12",  1'b1, 2'b11, 8'h90, 8'h0C, 8'hFF, 1'b0, 13);
    do_op("ashr0",   1'b0, 2'b11, 8'h90, 8'h00, 8'h90, 1'b0, 2);
    do_op("ashr_pos",1'b1, 2'b11, 8'h70, 8'h02, 8'h1C, 1'b0, 3);

    // arbitration: fresh reset so requester 0 is favoured
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ca[0] = 8'h01; cb[0] = 8'h10; left[0] = 4;
    ca[1] = 8'h50; cb[1] = 8'h05; left[1] = 4;
    set_req(1'b0, 1'b1, 2'b00, ca[0], cb[0]);
    set_req(1'b1, 1'b1, 2'b01, ca[1], cb[1]);
    #1;
    for (int i = 0; i < 8; i++) begin
      k = 0;
      while (!(bus.req0_ready || bus.req1_ready) && k < 20) begin
        tick(); #1;
        k++;
      end
      chk("arb_excl", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
      gid = bus.req1_ready ? 1 : 0;
      chk("arb_order", gid, i % 2);
      exp_d = (gid == 0) ? ca[0] + cb[0] : ca[1] - cb[1];
      tick();
      left[gid]--;
      ca[gid] = ca[gid] + 8'h11;
      set_req(gid[0], left[gid] > 0, (gid == 0) ? 2'b00 : 2'b01, ca[gid], cb[gid]);
      k = 0;
      while (!bus.rsp_valid && k < 20) begin
        tick();
        k++;
      end
      chk("arb_rsp_id", {31'd0, bus.rsp_id}, gid);
      chk("arb_rsp_data", {24'd0, bus.rsp_data}, {24'd0, exp_d});
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      #1;
    end

    // backpressure: hold DONE with both requesters pushing
    tick();
    set_req(1'b1, 1'b1, 2'b00, 8'h7F, 8'h01);
    tick();
    set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      tick();
      k++;
    end
    set_req(1'b0, 1'b1, 2'b00, 8'h01, 8'h01);
    set_req(1'b1, 1'b1, 2'b00, 8'h02, 8'h02);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_data",  {24'd0, bus.rsp_data}, 32'h80);
      chk("bp_id",    {31'd0, bus.rsp_id}, 32'd1);
      chk("bp_rdy",   {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      tick();
    end
    set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_release", {31'd0, bus.rsp_valid}, 32'd0);

    // reset mid ASHR n=10 from requester 0 (prio would otherwise point at 1)
    tick();
    set_req(1'b0, 1'b1, 2'b11, 8'h80, 8'h0A);
    #1;
    chk("rmid_grant", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    tick(); tick();
    rst = 1'b1;
    set_req(1'b1, 1'b1, 2'b00, 8'h01, 8'h02);
    tick();
    chk("rmid_rdy_in_rst", {31'd0, bus.req1_ready}, 32'd0);
    chk("rmid_valid", {31'd0, bus.rsp_valid}, 32'd0);
    set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    chk("rmid_no_rsp", seen, 0);
    set_req(1'b0, 1'b1, 2'b00, 8'h03, 8'h04);
    set_req(1'b1, 1'b1, 2'b00, 8'h05, 8'h06);
    #1;
    chk("rmid_prio0", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
    tick();
    set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      tick();
      k++;
    end
    chk("rmid_after_data", {24'd0, bus.rsp_data}, 32'h07);
    chk("rmid_after_id", {31'd0, bus.rsp_id}, 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
